adc_fill_framer: RTL and testbench
==================================

Name: adc_fill_framer

Overview:
- Parametrised successor to the single-waveform CBUF data mux.
- Frames one complete fill for the DDR3 write FIFO: fill header, then N waveforms (each a waveform header followed by M data bursts), then a checksum beat.
- Adds an internal sequencer FSM, valid/ready handshakes on input and output, multi-waveform (async) fills, configurable burst geometry, and an abort path.
- Sits between the per-channel ADC sample pipeline and the DDR3 write FIFO.

Parameters:
- NSAMP, 8, ADC samples per burst; must be even and ≥8.
- ADC_BITS, 12, ADC sample width, excluding the over-range bit; must be ≤15.
- DATA_W, NSAMP*16, payload width; each sample is sign-extended into a 16-bit word.
- TAG_W, 4, burst-contents tag width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous assert, active-low
- start  in  1  single-cycle pulse; begins a fill, ignored while busy=1
- abort  in  1  single-cycle pulse; terminates the fill early
- fill_num  in  24  fill number, latched at start
- fill_type  in  2  fill type, latched at start
- channel_tag  in  12  channel tag, latched at start
- num_wfm  in  23  waveforms in this fill, latched at start
- num_bursts  in  14  bursts per waveform, latched at start
- pre_trig  in  16  pre-trigger sample count, latched at start
- start_adr  in  23  first DDR3 burst address, latched at start
- xadc_alarms  in  4  sampled when each waveform header is built
- in_dat  in  NSAMP*(ADC_BITS+1)  samples, oldest in the LSBs; each sample is {data, ovr}
- in_valid  in  1  in_dat is valid
- in_ready  out  1  beat accepted when in_valid && in_ready
- out_dat  out  TAG_W+DATA_W  {tag, payload}
- out_valid  out  1  out_dat is valid
- out_ready  in  1  downstream FIFO can accept
- busy  out  1  high from start until the checksum beat is accepted
- ovr_seen  out  1  sticky over-range flag for the fill; cleared at start

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, checksum 0.
- States: IDLE, FHDR, WHDR, DATA, CSUM.
- IDLE → FHDR on start; busy and all configuration registers load on the same edge.
- FHDR, tag 1, one beat. Layout in payload [127:0]:
  - fill_num[23:0], fill_type[25:24], 0[26], num_bursts[40:27], pre_trig[11:0] at [52:41]
  - start_adr[75:53], num_wfm[98:76], pre_trig[15:12] at [102:99], 0[103]
  - channel_tag[121:110], 2'b01[127:126]; all other bits 0.
- WHDR, tag 2, one beat per waveform w (0-based). Layout:
  - num_bursts[13:0], pre_trig[11:0] at [25:14]
  - {start_adr + w*num_bursts, 3'b0} at [51:26], computed mod 2^23 before the shift, so the address wraps.
  - w+1 at [74:52], channel_tag[109:98], alarms[113:110], 0[114], 2'b01[127:126].
- DATA, tag 3, num_bursts beats per waveform.
  - Sample k occupies word k, sign-extended from ADC_BITS to 16 bits; the over-range bit is dropped.
  - Any over-range bit set in an accepted beat sets ovr_seen.
- Payload bits above 127 are 0 in header and checksum beats.
- Transitions:
  - FHDR → WHDR, or → CSUM if num_wfm = 0.
  - WHDR → DATA, or → next WHDR / CSUM if num_bursts = 0.
  - Last DATA beat → WHDR if w+1 < num_wfm, else → CSUM.
  - CSUM → IDLE when its beat is accepted.
- CSUM beat: tag 4 normally, tag 5 if the fill was aborted. Payload = XOR of the DATA_W payloads of every prior beat in the fill.
- Output register:
  - Every beat is registered, so out_dat/out_valid appear 1 cycle after the state or input acceptance that produces them.
  - While out_valid && !out_ready, out_dat is held stable.
  - The next beat loads only when !out_valid || out_ready.
  - Full-throughput streaming at 1 beat per clock when both sides are ready.
- in_ready = (state == DATA) && (!out_valid || out_ready). It is never asserted outside DATA, so no sample is ever consumed outside a waveform.
- The checksum updates on the same edge that a beat loads into the output register.
- Abort:
  - In FHDR, WHDR or DATA: any beat already in the output register completes normally, then the FSM jumps to CSUM with tag 5. No further in_dat is consumed.
  - Ignored in IDLE and CSUM.
- start while busy is ignored. start and abort in the same IDLE cycle: start wins and abort is dropped.
- Async reset mid-fill returns to IDLE, drops out_valid with no partial beat, and clears busy and ovr_seen.

Decomposition:
- Package adc_fill_pkg holds:
  - tag constants: TAG_FHDR=1, TAG_WHDR=2, TAG_DATA=3, TAG_CSUM=4, TAG_CSUM_ABORT=5
  - HDR_MARK=2'b01
  - state enum
  - header field bit-position constants
- One sub-module, adc_fill_outreg: the output register/skid stage with checksum accumulation.

Test Plan:
- num_wfm=1, num_bursts=4, NSAMP=8, ready always high → 7 consecutive beats tagged 1,2,3,3,3,3,4; checksum equals the XOR of the prior 6 payloads.
- num_wfm=3, num_bursts=2, start_adr=23'h7FFFFF → WHDR addresses 0x3FFFFF8, 0x0000008, 0x0000018 and indices 1,2,3.
- in_dat sample 0 = 13'h1FFE (data 0xFFF, ovr=0), sample 1 = 13'h0801 (data 0x400, ovr=1) → words 0xFFFF and 0x0400; ovr_seen=1.
- Random out_ready at 30% duty, num_bursts=5 → out_dat stable while stalled, no beat lost or duplicated, in_dat never consumed while stalled.
- Abort during the 2nd DATA beat of waveform 1 → remaining beats suppressed, final beat tag 5, busy falls after it is accepted; num_wfm=0 → FHDR then CSUM only.
- rst_n low mid-DATA → out_valid, busy, ovr_seen all 0 immediately; a new start yields a clean fill whose checksum excludes pre-reset beats.

Source files
------------

// File: rtl/adc_fill_pkg.sv
// ---------------------------------------------------------------------------
// adc_fill_pkg
// Shared definitions for the ADC fill framer: beat tags, the header marker,
// the sequencer state encoding and the bit positions of every header field.
// Header fields always live in payload bits [127:0]; anything above is zero.
// ---------------------------------------------------------------------------
package adc_fill_pkg;

    // Burst-contents tags carried in the top TAG_W bits of out_dat
    localparam int TAG_FHDR       = 1;
    localparam int TAG_WHDR       = 2;
    localparam int TAG_DATA       = 3;
    localparam int TAG_CSUM       = 4;
    localparam int TAG_CSUM_ABORT = 5;

    // Marker in the top two bits of every header word
    localparam logic [1:0] HDR_MARK     = 2'b01;
    localparam int         HDR_MARK_POS = 126;
    localparam int         HDR_W        = 128;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_FHDR = 3'd1,
        ST_WHDR = 3'd2,
        ST_DATA = 3'd3,
        ST_CSUM = 3'd4
    } state_e;

    // Fill header field LSB positions
    localparam int FH_FILL_NUM   = 0;
    localparam int FH_FILL_TYPE  = 24;
    localparam int FH_NBURST     = 27;
    localparam int FH_PRETRIG_LO = 41;
    localparam int FH_START_ADR  = 53;
    localparam int FH_NUM_WFM    = 76;
    localparam int FH_PRETRIG_HI = 99;
    localparam int FH_CHAN_TAG   = 110;

    // Waveform header field LSB positions
    localparam int WH_NBURST     = 0;
    localparam int WH_PRETRIG    = 14;
    localparam int WH_ADR        = 26;
    localparam int WH_INDEX      = 52;
    localparam int WH_CHAN_TAG   = 98;
    localparam int WH_ALARMS     = 110;

endpackage

// File: rtl/adc_fill_outreg.sv
// ---------------------------------------------------------------------------
// adc_fill_outreg
// Output register of the fill framer with checksum accumulation. A beat is
// captured on load; it is held stable until the downstream side accepts it.
// The running checksum XORs the payload of every beat as it is captured.
//   clk, rst_n   : clock, asynchronous active-low reset
//   clr          : clear the running checksum (start of a fill)
//   load         : capture {ld_tag, ld_payload}; only asserted when the
//                  register is empty or being drained this cycle
//   out_ready    : downstream accept
//   out_dat      : registered {tag, payload}
//   out_valid    : out_dat holds an unaccepted beat
//   csum         : XOR of all payloads captured since the last clr
// ---------------------------------------------------------------------------
module adc_fill_outreg #(
    parameter int TAG_W  = 4,
    parameter int DATA_W = 128
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    load,
    input  logic [TAG_W-1:0]        ld_tag,
    input  logic [DATA_W-1:0]       ld_payload,
    input  logic                    out_ready,
    output logic [TAG_W+DATA_W-1:0] out_dat,
    output logic                    out_valid,
    output logic [DATA_W-1:0]       csum
);

    logic [TAG_W+DATA_W-1:0] dat_q, dat_d;
    logic                    valid_q, valid_d;
    logic [DATA_W-1:0]       csum_q, csum_d;

    always_comb begin
        dat_d   = dat_q;
        valid_d = valid_q;
        csum_d  = csum_q;
        if (clr) begin
            csum_d = '0;
        end
        if (load) begin
            dat_d   = {ld_tag, ld_payload};
            valid_d = 1'b1;
            csum_d  = csum_q ^ ld_payload;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dat_q   <= '0;
            valid_q <= 1'b0;
            csum_q  <= '0;
        end else begin
            dat_q   <= dat_d;
            valid_q <= valid_d;
            csum_q  <= csum_d;
        end
    end

    assign out_dat   = dat_q;
    assign out_valid = valid_q;
    assign csum      = csum_q;

endmodule

// File: rtl/adc_fill_framer.sv
// ---------------------------------------------------------------------------
// adc_fill_framer
// Frames one complete fill for the DDR3 write FIFO: a fill header, then
// num_wfm waveforms (waveform header + num_bursts data beats each), then a
// checksum beat (XOR of all prior payloads). An abort pulse cuts the fill
// short and ends it with an abort-tagged checksum.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start, abort        : single-cycle control pulses
//   fill_num .. start_adr: fill configuration, latched at start
//   xadc_alarms         : sampled into each waveform header
//   in_dat/in_valid/in_ready : ADC sample beats, {data, ovr} per sample
//   out_dat/out_valid/out_ready : {tag, payload} beats to the write FIFO
//   busy                : start accepted, checksum beat not yet accepted
//   ovr_seen            : sticky over-range flag for the current fill
// ---------------------------------------------------------------------------
module adc_fill_framer
    import adc_fill_pkg::*;
#(
    parameter int NSAMP    = 8,
    parameter int ADC_BITS = 12,
    parameter int DATA_W   = NSAMP*16,
    parameter int TAG_W    = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          abort,
    input  logic [23:0]                   fill_num,
    input  logic [1:0]                    fill_type,
    input  logic [11:0]                   channel_tag,
    input  logic [22:0]                   num_wfm,
    input  logic [13:0]                   num_bursts,
    input  logic [15:0]                   pre_trig,
    input  logic [22:0]                   start_adr,
    input  logic [3:0]                    xadc_alarms,
    input  logic [NSAMP*(ADC_BITS+1)-1:0] in_dat,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [TAG_W+DATA_W-1:0]       out_dat,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          busy,
    output logic                          ovr_seen
);

    localparam int SAMP_W = ADC_BITS + 1;

    function automatic logic [15:0] sext_sample(input logic [ADC_BITS-1:0] raw);
        logic signed [ADC_BITS-1:0] s;
        s = signed'(raw);
        return 16'(s);
    endfunction

    state_e      state_q, state_d;
    logic [23:0] fill_num_q, fill_num_d;
    logic [1:0]  fill_type_q, fill_type_d;
    logic [11:0] chan_tag_q, chan_tag_d;
    logic [22:0] num_wfm_q, num_wfm_d;
    logic [13:0] num_bursts_q, num_bursts_d;
    logic [15:0] pre_trig_q, pre_trig_d;
    logic [22:0] start_adr_q, start_adr_d;
    logic [22:0] wfm_q, wfm_d;         // current waveform index
    logic [13:0] burst_q, burst_d;     // data beat index within the waveform
    logic [22:0] wadr_q, wadr_d;       // burst address of the current waveform
    logic        aborted_q, aborted_d;
    logic        csum_sent_q, csum_sent_d;
    logic        busy_q, busy_d;
    logic        ovr_seen_q, ovr_seen_d;

    logic              can_load;
    logic              ld;
    logic              clr;
    logic [TAG_W-1:0]  ld_tag;
    logic [DATA_W-1:0] ld_payload;
    logic [DATA_W-1:0] csum;
    logic [HDR_W-1:0]  fhdr;
    logic [HDR_W-1:0]  whdr;
    logic [DATA_W-1:0] data_pl;
    logic              data_ovr;
    logic              more_wfm;

    // The output register can take a new beat when empty or draining now
    assign can_load = !out_valid || out_ready;
    assign in_ready = (state_q == ST_DATA) && can_load;
    assign busy     = busy_q;
    assign ovr_seen = ovr_seen_q;

    // Widened so that num_wfm = 2^23-1 does not overflow the compare
    assign more_wfm = ({1'b0, wfm_q} + 24'd1) < {1'b0, num_wfm_q};

    always_comb begin
        fhdr = '0;
        fhdr[FH_FILL_NUM   +: 24] = fill_num_q;
        fhdr[FH_FILL_TYPE  +: 2]  = fill_type_q;
        fhdr[FH_NBURST     +: 14] = num_bursts_q;
        fhdr[FH_PRETRIG_LO +: 12] = pre_trig_q[11:0];
        fhdr[FH_START_ADR  +: 23] = start_adr_q;
        fhdr[FH_NUM_WFM    +: 23] = num_wfm_q;
        fhdr[FH_PRETRIG_HI +: 4]  = pre_trig_q[15:12];
        fhdr[FH_CHAN_TAG   +: 12] = chan_tag_q;
        fhdr[HDR_MARK_POS  +: 2]  = HDR_MARK;
    end

    always_comb begin
        whdr = '0;
        whdr[WH_NBURST    +: 14] = num_bursts_q;
        whdr[WH_PRETRIG   +: 12] = pre_trig_q[11:0];
        whdr[WH_ADR       +: 26] = {wadr_q, 3'b000};
        whdr[WH_INDEX     +: 23] = wfm_q + 23'd1;
        whdr[WH_CHAN_TAG  +: 12] = chan_tag_q;
        whdr[WH_ALARMS    +: 4]  = xadc_alarms;
        whdr[HDR_MARK_POS +: 2]  = HDR_MARK;
    end

    always_comb begin
        data_pl  = '0;
        data_ovr = 1'b0;
        for (int k = 0; k < NSAMP; k++) begin
            data_pl[k*16 +: 16] = sext_sample(in_dat[k*SAMP_W+1 +: ADC_BITS]);
            data_ovr            = data_ovr | in_dat[k*SAMP_W];
        end
    end

    always_comb begin
        state_d      = state_q;
        fill_num_d   = fill_num_q;
        fill_type_d  = fill_type_q;
        chan_tag_d   = chan_tag_q;
        num_wfm_d    = num_wfm_q;
        num_bursts_d = num_bursts_q;
        pre_trig_d   = pre_trig_q;
        start_adr_d  = start_adr_q;
        wfm_d        = wfm_q;
        burst_d      = burst_q;
        wadr_d       = wadr_q;
        aborted_d    = aborted_q;
        csum_sent_d  = csum_sent_q;
        busy_d       = busy_q;
        ovr_seen_d   = ovr_seen_q;
        ld           = 1'b0;
        clr          = 1'b0;
        ld_tag       = '0;
        ld_payload   = '0;

        unique case (state_q)
            ST_IDLE: begin
                // abort in the same cycle is simply not looked at here
                if (start) begin
                    state_d      = ST_FHDR;
                    busy_d       = 1'b1;
                    fill_num_d   = fill_num;
                    fill_type_d  = fill_type;
                    chan_tag_d   = channel_tag;
                    num_wfm_d    = num_wfm;
                    num_bursts_d = num_bursts;
                    pre_trig_d   = pre_trig;
                    start_adr_d  = start_adr;
                    wfm_d        = '0;
                    burst_d      = '0;
                    wadr_d       = start_adr;
                    aborted_d    = 1'b0;
                    csum_sent_d  = 1'b0;
                    ovr_seen_d   = 1'b0;
                    clr          = 1'b1;
                end
            end

            ST_FHDR: begin
                if (abort) begin
                    state_d   = ST_CSUM;
                    aborted_d = 1'b1;
                end else if (can_load) begin
                    ld         = 1'b1;
                    ld_tag     = TAG_W'(TAG_FHDR);
                    ld_payload = DATA_W'(fhdr);
                    state_d    = (num_wfm_q == '0) ? ST_CSUM : ST_WHDR;
                end
            end

            ST_WHDR: begin
                if (abort) begin
                    state_d   = ST_CSUM;
                    aborted_d = 1'b1;
                end else if (can_load) begin
                    ld         = 1'b1;
                    ld_tag     = TAG_W'(TAG_WHDR);
                    ld_payload = DATA_W'(whdr);
                    burst_d    = '0;
                    if (num_bursts_q != '0) begin
                        state_d = ST_DATA;
                    end else begin
                        // Empty waveform: header only, address does not advance
                        wfm_d   = wfm_q + 23'd1;
                        state_d = more_wfm ? ST_WHDR : ST_CSUM;
                    end
                end
            end

            ST_DATA: begin
                // A beat handshaken in the abort cycle has already been
                // consumed upstream, so it is still framed before the jump.
                if (in_valid && in_ready) begin
                    ld         = 1'b1;
                    ld_tag     = TAG_W'(TAG_DATA);
                    ld_payload = data_pl;
                    ovr_seen_d = ovr_seen_q | data_ovr;
                    if (burst_q == num_bursts_q - 14'd1) begin
                        burst_d = '0;
                        wfm_d   = wfm_q + 23'd1;
                        wadr_d  = wadr_q + 23'(num_bursts_q);
                        state_d = more_wfm ? ST_WHDR : ST_CSUM;
                    end else begin
                        burst_d = burst_q + 14'd1;
                    end
                end
                if (abort) begin
                    state_d   = ST_CSUM;
                    aborted_d = 1'b1;
                end
            end

            ST_CSUM: begin
                if (!csum_sent_q) begin
                    if (can_load) begin
                        ld          = 1'b1;
                        ld_tag      = aborted_q ? TAG_W'(TAG_CSUM_ABORT) : TAG_W'(TAG_CSUM);
                        ld_payload  = DATA_W'(csum[HDR_W-1:0]);
                        csum_sent_d = 1'b1;
                    end
                end else if (out_valid && out_ready) begin
                    // The checksum is the only beat left in the register
                    state_d     = ST_IDLE;
                    busy_d      = 1'b0;
                    csum_sent_d = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            fill_num_q   <= '0;
            fill_type_q  <= '0;
            chan_tag_q   <= '0;
            num_wfm_q    <= '0;
            num_bursts_q <= '0;
            pre_trig_q   <= '0;
            start_adr_q  <= '0;
            wfm_q        <= '0;
            burst_q      <= '0;
            wadr_q       <= '0;
            aborted_q    <= 1'b0;
            csum_sent_q  <= 1'b0;
            busy_q       <= 1'b0;
            ovr_seen_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            fill_num_q   <= fill_num_d;
            fill_type_q  <= fill_type_d;
            chan_tag_q   <= chan_tag_d;
            num_wfm_q    <= num_wfm_d;
            num_bursts_q <= num_bursts_d;
            pre_trig_q   <= pre_trig_d;
            start_adr_q  <= start_adr_d;
            wfm_q        <= wfm_d;
            burst_q      <= burst_d;
            wadr_q       <= wadr_d;
            aborted_q    <= aborted_d;
            csum_sent_q  <= csum_sent_d;
            busy_q       <= busy_d;
            ovr_seen_q   <= ovr_seen_d;
        end
    end

    adc_fill_outreg #(
        .TAG_W  (TAG_W),
        .DATA_W (DATA_W)
    ) u_outreg (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .load       (ld),
        .ld_tag     (ld_tag),
        .ld_payload (ld_payload),
        .out_ready  (out_ready),
        .out_dat    (out_dat),
        .out_valid  (out_valid),
        .csum       (csum)
    );

endmodule

// File: tb/tb_adc_fill_framer.sv
// ---------------------------------------------------------------------------
// tb_adc_fill_framer
// Scoreboard bench: each fill's complete expected beat sequence is built from
// the field rules and pushed to a queue when the fill is issued; a monitor
// pops and compares every beat the DUT hands downstream.
// ---------------------------------------------------------------------------
module tb_adc_fill_framer;

    localparam int NSAMP    = 8;
    localparam int ADC_BITS = 12;
    localparam int DATA_W   = 128;
    localparam int TAG_W    = 4;
    localparam int SW       = ADC_BITS + 1;
    localparam int IW       = NSAMP * SW;
    localparam int OW       = TAG_W + DATA_W;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [23:0]   fill_num = '0;
    logic [1:0]    fill_type = '0;
    logic [11:0]   channel_tag = '0;
    logic [22:0]   num_wfm = '0;
    logic [13:0]   num_bursts = '0;
    logic [15:0]   pre_trig = '0;
    logic [22:0]   start_adr = '0;
    logic [3:0]    xadc_alarms = '0;
    logic [IW-1:0] in_dat = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [OW-1:0] out_dat;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          busy;
    logic          ovr_seen;

    int n_tests = 0;
    int n_fail  = 0;
    int ready_pct = 100;

    logic [OW-1:0]     exp_q[$];
    logic [DATA_W-1:0] m_csum;

    always #5 clk = ~clk;

    adc_fill_framer #(
        .NSAMP    (NSAMP),
        .ADC_BITS (ADC_BITS),
        .DATA_W   (DATA_W),
        .TAG_W    (TAG_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .fill_num    (fill_num),
        .fill_type   (fill_type),
        .channel_tag (channel_tag),
        .num_wfm     (num_wfm),
        .num_bursts  (num_bursts),
        .pre_trig    (pre_trig),
        .start_adr   (start_adr),
        .xadc_alarms (xadc_alarms),
        .in_dat      (in_dat),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_dat     (out_dat),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .ovr_seen    (ovr_seen)
    );

    task automatic chk(input string nm, input logic [OW:0] act, input logic [OW:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [DATA_W-1:0] m_fhdr();
        logic [DATA_W-1:0] p;
        p = '0;
        p[23:0]    = fill_num;
        p[25:24]   = fill_type;
        p[40:27]   = num_bursts;
        p[52:41]   = pre_trig[11:0];
        p[75:53]   = start_adr;
        p[98:76]   = num_wfm;
        p[102:99]  = pre_trig[15:12];
        p[121:110] = channel_tag;
        p[127:126] = 2'b01;
        return p;
    endfunction

    function automatic logic [DATA_W-1:0] m_whdr(input int w);
        logic [DATA_W-1:0] p;
        logic [22:0]       a;
        a = 23'((longint'(start_adr) + longint'(w) * longint'(num_bursts)) % 64'd8388608);
        p = '0;
        p[13:0]    = num_bursts;
        p[25:14]   = pre_trig[11:0];
        p[51:26]   = {a, 3'b000};
        p[74:52]   = 23'(w + 1);
        p[109:98]  = channel_tag;
        p[113:110] = xadc_alarms;
        p[127:126] = 2'b01;
        return p;
    endfunction

    function automatic logic [DATA_W-1:0] m_data(input logic [IW-1:0] v);
        logic [DATA_W-1:0] p;
        int d;
        p = '0;
        for (int k = 0; k < NSAMP; k++) begin
            d = int'(v[k*SW+1 +: ADC_BITS]);
            if (d >= (1 << (ADC_BITS-1))) d = d - (1 << ADC_BITS);
            p[k*16 +: 16] = 16'(d);
        end
        return p;
    endfunction

    function automatic bit m_ovr(input logic [IW-1:0] v);
        bit o;
        o = 1'b0;
        for (int k = 0; k < NSAMP; k++) o = o | v[k*SW];
        return o;
    endfunction

    function automatic logic [IW-1:0] rand_in();
        logic [IW-1:0] v;
        v = IW'({$urandom, $urandom, $urandom, $urandom});
        for (int k = 0; k < NSAMP; k++) v[k*SW] = 1'b0;
        if ($urandom_range(7) == 0) v[$urandom_range(NSAMP-1)*SW] = 1'b1;
        return v;
    endfunction

    task automatic push_exp(input int tag, input logic [DATA_W-1:0] p);
        exp_q.push_back({4'(tag), p});
        m_csum = m_csum ^ p;
    endtask

    // ---------------- downstream ready ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = ($urandom_range(99) < ready_pct);
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic [OW-1:0] prev_dat;
    bit            prev_stall = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                chk("stall_hold", {out_valid, out_dat}, {1'b1, prev_dat});
            if (out_valid && !out_ready)
                chk("no_consume_while_stalled", OW'(in_ready), '0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", {1'b1, out_dat}, '0);
                end else begin
                    chk("beat", {1'b0, out_dat}, {1'b0, exp_q.pop_front()});
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_dat   = out_dat;
        end
    end

    // ---------------- one fill ----------------
    task automatic run_fill(input int nw, input int nb, input logic [22:0] sa,
                            input int rpct, input int abort_at, input int rst_at,
                            input bit directed);
        logic [IW-1:0] samples[$];
        int  total, nsend, cnt, sent, cyc, extra;
        bit  stop, exp_ovr, hs;

        fill_num    = 24'($urandom);
        fill_type   = 2'($urandom);
        channel_tag = 12'($urandom);
        num_wfm     = 23'(nw);
        num_bursts  = 14'(nb);
        pre_trig    = 16'($urandom);
        start_adr   = sa;
        xadc_alarms = 4'($urandom);
        ready_pct   = rpct;

        total = nw * nb;
        for (int i = 0; i < total; i++) samples.push_back(rand_in());
        if (directed && total > 0) begin
            samples[0][0*SW +: SW] = 13'h1FFE;
            samples[0][1*SW +: SW] = 13'h0801;
        end
        nsend = total;
        if (abort_at >= 0) nsend = abort_at;
        if (rst_at >= 0)   nsend = rst_at;

        // expected beat sequence for the whole fill
        m_csum  = '0;
        exp_ovr = 1'b0;
        cnt     = 0;
        stop    = 1'b0;
        push_exp(1, m_fhdr());
        for (int w = 0; w < nw && !stop; w++) begin
            push_exp(2, m_whdr(w));
            for (int b = 0; b < nb && !stop; b++) begin
                if (abort_at >= 0 && cnt == nsend) begin
                    stop = 1'b1;
                end else begin
                    push_exp(3, m_data(samples[cnt]));
                    exp_ovr = exp_ovr | m_ovr(samples[cnt]);
                    cnt++;
                end
            end
        end
        push_exp((abort_at >= 0) ? 5 : 4, m_csum);

        // start together with abort: start must win
        @(posedge clk); #1;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        chk("busy_after_start", OW'(busy), OW'(1));
        // a second start while busy must be ignored
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;

        sent = 0;
        cyc  = 0;
        while (sent < nsend && cyc < 5000) begin
            in_valid = ($urandom_range(3) != 0);
            in_dat   = samples[sent];
            @(negedge clk);
            hs = in_valid && in_ready;
            @(posedge clk); #1;
            if (hs) sent++;
            cyc++;
        end
        in_valid = 1'b0;
        if (cyc >= 5000) chk("drive_timeout", OW'(sent), OW'(nsend));

        if (rst_at >= 0) begin
            chk("ovr_before_reset", OW'(ovr_seen), OW'(exp_ovr));
            rst_n = 1'b0;
            #1;
            chk("reset_mid_fill", {out_valid, busy, ovr_seen, in_ready}, '0);
            exp_q.delete();
            @(posedge clk); #1;
            rst_n = 1'b1;
            return;
        end

        if (abort_at >= 0) begin
            abort = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
        end

        // drain: in_valid held high, nothing may be consumed any more
        in_valid = 1'b1;
        in_dat   = rand_in();
        cyc      = 0;
        extra    = 0;
        while (busy && cyc < 5000) begin
            @(negedge clk);
            if (in_ready) extra++;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        chk("busy_end", OW'(busy), '0);
        chk("no_extra_consume", OW'(extra), '0);
        chk("beats_left", OW'(exp_q.size()), '0);
        chk("ovr_seen", OW'(ovr_seen), OW'(exp_ovr));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {out_valid, busy, ovr_seen, in_ready, out_dat}, '0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_after_reset", {out_valid, busy, in_ready}, '0);

        run_fill(1, 4, 23'($urandom), 100, -1, -1, 1'b0);
        run_fill(3, 2, 23'h7FFFFF,    100, -1, -1, 1'b0);
        run_fill(1, 2, 23'($urandom), 100, -1, -1, 1'b1);
        run_fill(2, 5, 23'($urandom), 30,  -1, -1, 1'b0);
        run_fill(2, 3, 23'($urandom), 60,   4, -1, 1'b0);
        run_fill(0, 4, 23'($urandom), 100, -1, -1, 1'b0);
        run_fill(2, 0, 23'($urandom), 50,  -1, -1, 1'b0);
        run_fill(2, 4, 23'($urandom), 70,  -1,  3, 1'b1);
        run_fill(1, 3, 23'($urandom), 100, -1, -1, 1'b0);
        for (int i = 0; i < 4; i++)
            run_fill(int'($urandom_range(3, 1)), int'($urandom_range(4, 1)),
                     23'($urandom), 50, -1, -1, 1'b0);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
